alu_result_stage: RTL and testbench
===================================

ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

Interface
REQ-001 SHALL provide parameter WIDTH, default 32: datapath width of the ALU result.
REQ-002 SHALL provide parameter RD_W, default 5: destination-register index width.
REQ-003 SHALL have clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have in_valid  input  1  upstream ALU result and flags are valid this cycle.
REQ-006 SHALL have in_ready  output  1  stage can accept an entry this cycle.
REQ-007 SHALL have in_result  input  WIDTH  ALU Result.
REQ-008 SHALL have in_carry, in_zero, in_overflow, in_negative  input  1 each  ALU CarryOut, Zero, Overflow and negative flags.
REQ-009 SHALL have in_rd  input  RD_W  destination register index.
REQ-010 SHALL have in_rc, in_oe, in_ca_we  input  1 each  update CR0, update SO/OV, update CA.
REQ-011 SHALL have so_clr  input  1  single-cycle pulse clearing sticky SO.
REQ-012 SHALL have out_valid  output  1  head entry presented downstream.
REQ-013 SHALL have out_ready  input  1  downstream accepts the head entry.
REQ-014 SHALL have out_result  output  WIDTH, out_rd  output  RD_W, out_cr_we  output  1, out_cr0  output  4 (LT,GT,EQ,SO): head-entry fields.
REQ-015 SHALL have xer_so, xer_ov, xer_ca  output  1 each  architectural XER bits.

Function
REQ-016 SHALL buffer entries in a 2-entry in-order FIFO; count in {0,1,2}.
REQ-017 SHALL accept (push) when in_valid && in_ready; pop when out_valid && out_ready.
REQ-018 SHALL drive in_ready = (count != 2) from registered state only; no combinational path from out_ready to in_ready.
REQ-019 SHALL drive out_valid = (count != 0); the head fields SHALL hold stable while out_valid && !out_ready.
REQ-020 SHALL give one-cycle latency: an entry pushed at edge N is visible on out_* after edge N.
REQ-021 SHALL, on push and pop in the same cycle with count 1, keep count 1 and present the new entry; with count 2 no push occurs.
REQ-022 SHALL update XER at push time, in acceptance order: if in_oe, xer_ov <= in_overflow; if in_ca_we, xer_ca <= in_carry.
REQ-023 SHALL set xer_so sticky when in_oe && in_overflow on push; so_clr clears it; simultaneous so_clr and set leaves xer_so = 1.
REQ-024 SHALL compute the entry CR0 at push: LT = in_negative, GT = !in_negative && !in_zero, EQ = in_zero, SO = next-state xer_so (including this push's set and a same-cycle clear).
REQ-025 SHALL store out_cr_we = in_rc per entry; out_cr0 SHALL be 4'b0000 in entries with in_rc = 0.
REQ-026 SHALL leave XER unchanged and ignore in_* when no push occurs (in_valid=0 or full).
REQ-027 SHALL honour so_clr in any cycle regardless of push/pop.

Reset
REQ-028 SHALL, while rst_n = 0, force count 0, out_valid 0, in_ready 1, out_result 0, out_rd 0, out_cr_we 0, out_cr0 0, xer_so/ov/ca 0.
REQ-029 SHALL, when rst_n asserts mid-operation, discard all buffered entries immediately, without waiting for a clock edge.
REQ-030 SHALL accept a push on the first rising edge after rst_n deasserts.

Verification
REQ-031 Single push: result 0x0000_0005, rd 3, rc=1, neg=0, zero=0 with out_ready=1 -> next cycle out_valid=1, out_result=5, out_rd=3, out_cr0=4'b0100.
REQ-032 Backpressure: out_ready=0, three back-to-back pushes A,B,C -> in_ready=0 after two, C not accepted; release out_ready -> A then B, in order, C accepted when in_ready=1.
REQ-033 Sticky SO: push oe=1, overflow=1 -> xer_so=1, xer_ov=1; push oe=1, overflow=0 -> xer_ov=0, xer_so=1; so_clr pulse -> xer_so=0.
REQ-034 Clear/set race: so_clr=1 with push oe=1, overflow=1, rc=1 -> xer_so=1 and entry out_cr0[0]=1.
REQ-035 Zero/CA: result 0, zero=1, carry=1, ca_we=1, rc=1 -> out_cr0=4'b0010, xer_ca=1; next push ca_we=0, carry=0 -> xer_ca stays 1.
REQ-036 Reset mid-operation: count 2, xer_so=1, assert rst_n=0 between edges -> out_valid=0, in_ready=1, all XER bits 0 immediately.

Source files
------------

// File: rtl/alu_result_stage.sv
// ALU result stage: a 2-entry in-order buffer between the ALU and writeback.
// It also owns the architectural XER bits and builds each entry's CR0 field.
module alu_result_stage #(
    parameter int WIDTH = 32,
    parameter int RD_W  = 5
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_result,
    input  logic             in_carry,
    input  logic             in_zero,
    input  logic             in_overflow,
    input  logic             in_negative,
    input  logic [RD_W-1:0]  in_rd,
    input  logic             in_rc,
    input  logic             in_oe,
    input  logic             in_ca_we,

    input  logic             so_clr,

    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [RD_W-1:0]  out_rd,
    output logic             out_cr_we,
    output logic [3:0]       out_cr0,

    output logic             xer_so,
    output logic             xer_ov,
    output logic             xer_ca
);

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic [RD_W-1:0]  rd;
        logic             cr_we;
        logic [3:0]       cr0;   // {LT, GT, EQ, SO}
    } entry_t;

    entry_t     slots [0:1];
    logic       rd_ptr;
    logic       wr_ptr;
    logic [1:0] count;

    logic       push;
    logic       pop;
    entry_t     new_entry;
    entry_t     head;
    logic       so_next;
    logic       ov_next;
    logic       ca_next;

    // Handshakes depend on registered count only, so out_ready never reaches in_ready.
    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        // NOTE: every signal gets a default before any conditional update, so no latch is inferred.
        so_next   = (xer_so && !so_clr) || (push && in_oe && in_overflow);
        ov_next   = xer_ov;
        ca_next   = xer_ca;
        new_entry = '0;

        if (push && in_oe) begin
            ov_next = in_overflow;
        end
        if (push && in_ca_we) begin
            ca_next = in_carry;
        end

        new_entry.result = in_result;
        new_entry.rd     = in_rd;
        new_entry.cr_we  = in_rc;
        // CR0.SO reflects the XER state this very push produces.
        if (in_rc) begin
            new_entry.cr0 = {in_negative, !in_negative && !in_zero, in_zero, so_next};
        end
    end

    // NOTE: the two slots are reset because their contents reach the outputs directly while in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slots[0] <= '0;
            slots[1] <= '0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            count    <= 2'd0;
        end else begin
            if (push) begin
                slots[wr_ptr] <= new_entry;
                wr_ptr        <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xer_so <= 1'b0;
            xer_ov <= 1'b0;
            xer_ca <= 1'b0;
        end else begin
            xer_so <= so_next;
            xer_ov <= ov_next;
            xer_ca <= ca_next;
        end
    end

    assign head       = slots[rd_ptr];
    assign out_result = head.result;
    assign out_rd     = head.rd;
    assign out_cr_we  = head.cr_we;
    assign out_cr0    = head.cr0;

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: directed scenarios plus random traffic
// compared against a queue-based reference model of the stage.
module tb_alu_result_stage;

    localparam int WIDTH = 32;
    localparam int RD_W  = 5;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_result = '0;
    logic             in_carry = 1'b0;
    logic             in_zero = 1'b0;
    logic             in_overflow = 1'b0;
    logic             in_negative = 1'b0;
    logic [RD_W-1:0]  in_rd = '0;
    logic             in_rc = 1'b0;
    logic             in_oe = 1'b0;
    logic             in_ca_we = 1'b0;
    logic             so_clr = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_result;
    logic [RD_W-1:0]  out_rd;
    logic             out_cr_we;
    logic [3:0]       out_cr0;
    logic             xer_so;
    logic             xer_ov;
    logic             xer_ca;

    alu_result_stage #(.WIDTH(WIDTH), .RD_W(RD_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
        .in_carry(in_carry), .in_zero(in_zero), .in_overflow(in_overflow),
        .in_negative(in_negative), .in_rd(in_rd), .in_rc(in_rc), .in_oe(in_oe),
        .in_ca_we(in_ca_we), .so_clr(so_clr),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_rd(out_rd), .out_cr_we(out_cr_we), .out_cr0(out_cr0),
        .xer_so(xer_so), .xer_ov(xer_ov), .xer_ca(xer_ca)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] result;
        logic [RD_W-1:0]  rd;
        logic             cr_we;
        logic [3:0]       cr0;
    } ent_t;

    ent_t q[$];
    logic m_so = 1'b0;
    logic m_ov = 1'b0;
    logic m_ca = 1'b0;
    int   checks = 0;
    int   failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".out_valid"}, 64'(out_valid), 64'(q.size() != 0));
        check({tag, ".in_ready"},  64'(in_ready),  64'(q.size() != 2));
        check({tag, ".xer_so"},    64'(xer_so),    64'(m_so));
        check({tag, ".xer_ov"},    64'(xer_ov),    64'(m_ov));
        check({tag, ".xer_ca"},    64'(xer_ca),    64'(m_ca));
        if (q.size() != 0) begin
            check({tag, ".out_result"}, 64'(out_result), 64'(q[0].result));
            check({tag, ".out_rd"},     64'(out_rd),     64'(q[0].rd));
            check({tag, ".out_cr_we"},  64'(out_cr_we),  64'(q[0].cr_we));
            check({tag, ".out_cr0"},    64'(out_cr0),    64'(q[0].cr0));
        end
    endtask

    // Called at posedge+1: drive inputs, check at the falling edge, then advance
    // the model across the next rising edge. Returns at posedge+1.
    task automatic step(input string tag, input logic v, input logic [WIDTH-1:0] res,
                        input logic [RD_W-1:0] rd, input logic rc, input logic oe,
                        input logic ovf, input logic ca_we, input logic carry,
                        input logic zero, input logic neg, input logic ordy,
                        input logic clr);
        logic push;
        logic pop;
        logic so_n;
        ent_t e;
        in_valid = v; in_result = res; in_rd = rd; in_rc = rc; in_oe = oe;
        in_overflow = ovf; in_ca_we = ca_we; in_carry = carry; in_zero = zero;
        in_negative = neg; out_ready = ordy; so_clr = clr;
        @(negedge clk);
        check_outputs(tag);
        push = v && (q.size() < 2);
        pop  = (q.size() > 0) && ordy;
        so_n = clr ? 1'b0 : m_so;
        if (push && oe && ovf) so_n = 1'b1;
        e.result = res;
        e.rd     = rd;
        e.cr_we  = rc;
        e.cr0    = rc ? {neg, !neg && !zero, zero, so_n} : 4'b0000;
        @(posedge clk);
        #1;
        if (pop) void'(q.pop_front());
        if (push) q.push_back(e);
        if (push && oe) m_ov = ovf;
        if (push && ca_we) m_ca = carry;
        m_so = so_n;
    endtask

    task automatic idle(input string tag, input logic ordy);
        step(tag, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ordy, 1'b0);
    endtask

    initial begin
        #2;
        check("reset.out_valid", 64'(out_valid), 64'd0);
        check("reset.in_ready",  64'(in_ready),  64'd1);
        check("reset.out_result", 64'(out_result), 64'd0);
        check("reset.xer", 64'({xer_so, xer_ov, xer_ca}), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single push accepted on the first edge after reset release.
        step("single", 1'b1, 32'h5, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("single.cr0", 64'(out_cr0), 64'b0100);
        check("single.result", 64'(out_result), 64'h5);
        idle("single.drain", 1'b1);

        // Backpressure: A, B fill the buffer, C is refused.
        step("bp.A", 1'b1, 32'hA, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("bp.B", 1'b1, 32'hB, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("bp.C", 1'b1, 32'hC, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("bp.full", 64'(in_ready), 64'd0);
        check("bp.headA", 64'(out_result), 64'hA);
        idle("bp.popA", 1'b1);
        check("bp.headB", 64'(out_result), 64'hB);
        step("bp.C2", 1'b1, 32'hC, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("bp.headC", 64'(out_result), 64'hC);
        idle("bp.drain", 1'b1);

        // Sticky SO.
        step("so.set", 1'b1, 32'h1, 5'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("so.set.bits", 64'({xer_so, xer_ov}), 64'b11);
        step("so.keep", 1'b1, 32'h2, 5'd6, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("so.keep.bits", 64'({xer_so, xer_ov}), 64'b10);
        step("so.clr", 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        check("so.clr.bit", 64'(xer_so), 64'd0);

        // Clear/set race: set wins and CR0.SO sees it.
        step("race", 1'b1, 32'h7, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        check("race.so", 64'(xer_so), 64'd1);
        check("race.cr0so", 64'(out_cr0[0]), 64'd1);
        step("race.clr", 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

        // Zero result with carry, then a push that must not touch CA.
        step("zca", 1'b1, 32'h0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        check("zca.cr0", 64'(out_cr0), 64'b0010);
        check("zca.ca", 64'(xer_ca), 64'd1);
        step("zca.keep", 1'b1, 32'h9, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("zca.keep.ca", 64'(xer_ca), 64'd1);
        idle("zca.drain", 1'b1);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step("rand", ($urandom_range(0, 9) < 7), $urandom(), RD_W'($urandom()),
                 1'($urandom()), 1'($urandom()), 1'($urandom()), 1'($urandom()),
                 1'($urandom()), ($urandom_range(0, 3) == 0), 1'($urandom()),
                 ($urandom_range(0, 9) < 6), ($urandom_range(0, 9) == 0));
        end

        // Asynchronous reset with a full buffer and SO set.
        step("rst.f1", 1'b1, 32'h11, 5'd1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step("rst.f2", 1'b1, 32'h22, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("rst.f3", 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("rst.out_valid", 64'(out_valid), 64'd0);
        check("rst.in_ready", 64'(in_ready), 64'd1);
        check("rst.xer", 64'({xer_so, xer_ov, xer_ca}), 64'd0);
        check("rst.fields", 64'({out_rd, out_cr_we, out_cr0}), 64'd0);
        q.delete();
        m_so = 1'b0;
        m_ov = 1'b0;
        m_ca = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step("post", 1'b1, 32'h33, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        idle("post.drain", 1'b1);
        idle("post.idle", 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
